// File: rtl/fp_div_arbiter_if.sv
// fp_div_arbiter_if: requester, response and divider signals of the shared FP divider arbiter
interface fp_div_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_req0_valid;
    logic [DATA_WIDTH-1:0] in_req0_numA;
    logic [DATA_WIDTH-1:0] in_req0_numB;
    logic                  out_req0_ready;
    logic                  in_req1_valid;
    logic [DATA_WIDTH-1:0] in_req1_numA;
    logic [DATA_WIDTH-1:0] in_req1_numB;
    logic                  out_req1_ready;
    logic                  out_resp0_valid;
    logic [DATA_WIDTH-1:0] out_resp0_result;
    logic                  out_resp0_divz;
    logic                  in_resp0_ready;
    logic                  out_resp1_valid;
    logic [DATA_WIDTH-1:0] out_resp1_result;
    logic                  out_resp1_divz;
    logic                  in_resp1_ready;
    logic [DATA_WIDTH-1:0] out_div_numA;
    logic [DATA_WIDTH-1:0] out_div_numB;
    logic [DATA_WIDTH-1:0] in_div_result;
    logic                  out_busy;

    modport slave (
        input  in_req0_valid, in_req0_numA, in_req0_numB,
        input  in_req1_valid, in_req1_numA, in_req1_numB,
        input  in_resp0_ready, in_resp1_ready, in_div_result,
        output out_req0_ready, out_req1_ready,
        output out_resp0_valid, out_resp0_result, out_resp0_divz,
        output out_resp1_valid, out_resp1_result, out_resp1_divz,
        output out_div_numA, out_div_numB, out_busy
    );

    modport master (
        output in_req0_valid, in_req0_numA, in_req0_numB,
        output in_req1_valid, in_req1_numA, in_req1_numB,
        output in_resp0_ready, in_resp1_ready, in_div_result,
        input  out_req0_ready, out_req1_ready,
        input  out_resp0_valid, out_resp0_result, out_resp0_divz,
        input  out_resp1_valid, out_resp1_result, out_resp1_divz,
        input  out_div_numA, out_div_numB, out_busy
    );
endinterface

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one combinational FP divider between two requesters
module fp_div_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int DIV_LATENCY = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    fp_div_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_owner;
    logic                  r_busy;
    logic                  r_rv0;
    logic                  r_rv1;
    logic                  r_divz;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_numA;
    logic [DATA_WIDTH-1:0] r_numB;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_idle;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_resp_hs;
    logic [DATA_WIDTH-1:0] w_numA;
    logic [DATA_WIDTH-1:0] w_numB;

    // requester 1 wins when alone, or when both ask and requester 0 was served last
    assign w_idle    = r_state == IDLE;
    assign w_grant1  = bus.in_req1_valid && (!bus.in_req0_valid || !r_last);
    assign w_accept  = w_idle && (bus.in_req0_valid || bus.in_req1_valid);
    assign w_numA    = w_grant1 ? bus.in_req1_numA : bus.in_req0_numA;
    assign w_numB    = w_grant1 ? bus.in_req1_numB : bus.in_req0_numB;
    assign w_zero    = w_numB[DATA_WIDTH-2:0] == '0;
    assign w_resp_hs = (r_rv0 && bus.in_resp0_ready) || (r_rv1 && bus.in_resp1_ready);

    assign bus.out_req0_ready   = w_idle && bus.in_req0_valid && !w_grant1;
    assign bus.out_req1_ready   = w_idle && w_grant1;
    assign bus.out_resp0_valid  = r_rv0;
    assign bus.out_resp1_valid  = r_rv1;
    assign bus.out_resp0_result = r_result;
    assign bus.out_resp1_result = r_result;
    assign bus.out_resp0_divz   = r_divz;
    assign bus.out_resp1_divz   = r_divz;
    assign bus.out_div_numA     = r_numA;
    assign bus.out_div_numB     = r_numB;
    assign bus.out_busy         = r_busy;

    // control FSM: accept and latch operands, hold them for the divider window, present the result
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_busy   <= 1'b0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
            r_divz   <= 1'b0;
            r_cnt    <= 4'd0;
            r_numA   <= '0;
            r_numB   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_numA  <= w_numA;
                    r_numB  <= w_numB;
                    r_owner <= w_grant1;
                    r_last  <= w_grant1;
                    r_busy  <= 1'b1;
                    if (w_zero) begin
                        r_result <= {w_numA[DATA_WIDTH-1] ^ w_numB[DATA_WIDTH-1], 11'h7FF, 52'd0};
                        r_divz   <= 1'b1;
                        r_rv0    <= !w_grant1;
                        r_rv1    <= w_grant1;
                        r_state  <= RESP;
                    end else begin
                        r_cnt   <= 4'(DIV_LATENCY - 1);
                        r_divz  <= 1'b0;
                        r_state <= EXEC;
                    end
                end
                EXEC: if (r_cnt == 4'd0) begin
                    r_result <= bus.in_div_result;
                    r_rv0    <= !r_owner;
                    r_rv1    <= r_owner;
                    r_state  <= RESP;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                RESP: if (w_resp_hs) begin
                    r_rv0   <= 1'b0;
                    r_rv1   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
- Controller and arbiter that shares one combinational 64-bit FP divider between two requesters (requester 0 and requester 1).
- Registers the operands and holds them stable to the divider for a programmable multicycle window, then captures the quotient and returns it to the requester that issued it.
- Uses round-robin arbitration, a valid/ready handshake on both request and response sides, and a divide-by-zero bypass.
- Sits between the FPU issue logic and the divider instance.

Parameters:
- DATA_WIDTH, 64, operand/result width (fixed by the divider; only 64 supported)
- DIV_LATENCY, 4, number of cycles operands are held to the divider before the result is sampled (legal range 1..15)

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_req0_valid  input  1  requester 0 has an operation
- in_req0_numA  input  64  requester 0 dividend
- in_req0_numB  input  64  requester 0 divisor
- out_req0_ready  output  1  requester 0 request accepted this cycle when high with valid
- in_req1_valid / in_req1_numA / in_req1_numB / out_req1_ready  as above, for requester 1
- out_resp0_valid  output  1  result for requester 0 available
- out_resp0_result  output  64  quotient
- out_resp0_divz  output  1  divide-by-zero flag, qualified by out_resp0_valid
- in_resp0_ready  input  1  requester 0 consumes the response
- out_resp1_valid / out_resp1_result / out_resp1_divz / in_resp1_ready  as above, for requester 1
- out_div_numA  output  64  registered dividend driven to the divider
- out_div_numB  output  64  registered divisor driven to the divider
- in_div_result  input  64  divider output
- out_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high. Every output register clears to 0. State goes to IDLE. The round-robin pointer is set to "last grant = 1", so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration and ready:
  - out_reqN_ready is high only in IDLE, and only for the granted requester.
  - Grant goes to the sole valid requester. If both are valid, grant goes to the requester not granted last.
  - Ready is combinational from state, pointer and valids. No ready is asserted when no valid is present.
- IDLE, accept cycle (valid && ready):
  - Latch numA/numB into the out_div_* registers, record the owner ID, and update the pointer to the owner.
  - If numB[62:0]==0: next state is RESP. Result register = {A[63]^B[63], 11'h7FF, 52'd0}, divz=1.
  - Otherwise: next state is EXEC. Counter = DIV_LATENCY-1, divz=0.
- EXEC:
  - Counter decrements each cycle.
  - When the counter is 0: capture in_div_result into the result register and go to RESP.
  - out_div_numA/B remain stable throughout EXEC.
- RESP:
  - out_respN_valid is high for the owner only. Result and divz are held stable until in_respN_ready is high.
  - On handshake: go to IDLE and deassert valid.
  - No new request is accepted in the handshake cycle. Throughput is one operation per DIV_LATENCY+2 cycles minimum.
- Latency, measured from the accept cycle (cycle 0):
  - Normal: response valid first at cycle DIV_LATENCY+1.
  - Divide-by-zero: response valid first at cycle 1.
- out_div_numA/B keep their last values in IDLE and RESP. They are not cleared after a transaction.
- Response ready from the non-owner is ignored. Response ready asserted while valid is low has no effect.
- A requester dropping valid before it is accepted is legal; nothing is issued.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. The response is never presented, and the pointer is restored to its reset value.
- No NaN/Inf/denormal handling beyond the divisor-zero bypass. The result is whatever the divider produces.

Test Plan:
- Basic divide, DIV_LATENCY=4, real divider attached:
  - Stimulus: req0 sends A=0x4018000000000000 (6.0), B=0x4000000000000000 (2.0).
  - Required: out_resp0_valid rises at cycle 5 after accept, result 0x4008000000000000, divz=0, out_busy high cycles 1..5.
- Divide by zero:
  - Stimulus: req1 sends A=0x3FF0000000000000, B=0x8000000000000000.
  - Required: out_resp1_valid at cycle 1, result 0xFFF0000000000000, divz=1. EXEC is never entered, and out_div_* are latched with the operands.
- Simultaneous requests after reset, both held valid:
  - Required: req0 is accepted first. req1 is accepted in the first IDLE cycle after req0's response handshake. On the next simultaneous pair, req0 wins again.
- Response back-pressure:
  - Stimulus: hold in_resp0_ready=0 for 10 cycles.
  - Required: valid and result stay stable, out_req0_ready and out_req1_ready stay 0, and completion occurs the cycle ready rises.
- Reset mid-operation:
  - Stimulus: assert in_rst in EXEC cycle 2.
  - Required: all outputs go to 0 immediately (asynchronously), no response appears, and the next simultaneous request grants req0.
- Wrong-owner ready:
  - Stimulus: req0 owns the response; drive in_resp1_ready=1 with in_resp0_ready=0.
  - Required: state stays RESP and out_resp0_valid stays 1.
